// File: rtl/case_item_scanner_if.sv
// Configuration/scan handshake bundle for case_item_scanner.
// CASE_SCAN_CASEZ_EN adds the per-entry don't-care mask input.
interface case_item_scanner_if #(
   parameter int N_ITEMS = 8,
   parameter int W       = 8
);
   localparam int IW = $clog2(N_ITEMS);
   localparam int WW = $clog2(W) + 1;

   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic          cfg_valid;
   logic [W-1:0]  cfg_val;
   logic [WW-1:0] cfg_width;
   logic          cfg_signed;
`ifdef CASE_SCAN_CASEZ_EN
   logic [W-1:0]  cfg_mask;
`endif
   logic          default_en;
   logic          start;
   logic [W-1:0]  sel_val;
   logic [WW-1:0] sel_width;
   logic          sel_signed;
   logic          busy;
   logic          done;
   logic          match_valid;
   logic [IW-1:0] match_idx;
   logic          hit_default;

   modport master (
`ifdef CASE_SCAN_CASEZ_EN
      output cfg_mask,
`endif
      output cfg_we, cfg_idx, cfg_valid, cfg_val, cfg_width, cfg_signed,
      output default_en, start, sel_val, sel_width, sel_signed,
      input  busy, done, match_valid, match_idx, hit_default
   );

   modport slave (
`ifdef CASE_SCAN_CASEZ_EN
      input  cfg_mask,
`endif
      input  cfg_we, cfg_idx, cfg_valid, cfg_val, cfg_width, cfg_signed,
      input  default_en, start, sel_val, sel_width, sel_signed,
      output busy, done, match_valid, match_idx, hit_default
   );
endinterface

// File: rtl/case_item_scanner.sv
// Sequential Verilog case evaluator: one shared comparator walks the item table.
// Optional casez-style masking is enabled with CASE_SCAN_CASEZ_EN.
module case_item_scanner #(
   parameter int N_ITEMS = 8,
   parameter int W       = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   case_item_scanner_if.slave   bus
);
   localparam int IW = $clog2(N_ITEMS);
   localparam int WW = $clog2(W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [N_ITEMS-1:0]  r_valid, r_signed;
   logic [W-1:0]        r_val   [N_ITEMS];
   logic [WW-1:0]       r_width [N_ITEMS];
`ifdef CASE_SCAN_CASEZ_EN
   logic [W-1:0]        r_mask  [N_ITEMS];
`endif
   logic [W-1:0]        r_sel_ext;
   logic [WW-1:0]       r_ctx_width;
   logic                r_ctx_signed, r_def_en;
   logic [IW-1:0]       r_idx, r_match_idx;
   logic                r_match_valid, r_hit_default;

   logic [WW-1:0]       w_ctx_width;
   logic                w_ctx_signed;
   logic [W-1:0]        w_sel_ext, w_item_ext, w_care;
   logic                w_hit, w_last, w_latch;
   logic [IW-1:0]       w_idx_nxt, w_midx_nxt;
   logic                w_mv_nxt, w_hd_nxt;

   // Mask to wd bits, then fill upper bits with the top valid bit when sgn is set.
   function automatic logic [W-1:0] f_extend(input logic [W-1:0] v, input logic [WW-1:0] wd,
                                             input logic sgn);
      logic         top;
      logic [W-1:0] r;
      top = 1'b0;
      for (int b = 0; b < W; b++)
         if (WW'(b) == wd - WW'(1)) top = v[b];
      for (int b = 0; b < W; b++)
         r[b] = (WW'(b) < wd) ? v[b] : (sgn & top);
      return r;
   endfunction

   function automatic logic [W-1:0] f_width_mask(input logic [WW-1:0] wd);
      logic [W-1:0] r;
      for (int b = 0; b < W; b++) r[b] = (WW'(b) < wd);
      return r;
   endfunction

   // Case context from the table as it stands when start is sampled.
   always_comb begin
      w_ctx_width  = bus.sel_width;
      w_ctx_signed = bus.sel_signed;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (r_valid[i]) begin
            if (r_width[i] > w_ctx_width) w_ctx_width = r_width[i];
            w_ctx_signed = w_ctx_signed & r_signed[i];
         end
      end
   end

   assign w_sel_ext  = f_extend(bus.sel_val, bus.sel_width, w_ctx_signed);
   assign w_item_ext = f_extend(r_val[r_idx], r_width[r_idx], r_ctx_signed);
`ifdef CASE_SCAN_CASEZ_EN
   // Mask extends with its own top bit regardless of context signedness.
   assign w_care = f_width_mask(r_ctx_width) & ~f_extend(r_mask[r_idx], r_width[r_idx], 1'b1);
`else
   assign w_care = f_width_mask(r_ctx_width);
`endif
   assign w_hit  = r_valid[r_idx] && (((r_sel_ext ^ w_item_ext) & w_care) == '0);
   assign w_last = (r_idx == IW'(N_ITEMS - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_mv_nxt    = r_match_valid;
      w_midx_nxt  = r_match_idx;
      w_hd_nxt    = r_hit_default;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_SCAN;
               w_latch     = 1'b1;
               w_idx_nxt   = '0;
               w_mv_nxt    = 1'b0;
               w_hd_nxt    = 1'b0;
            end
         end
         S_SCAN: begin
            if (w_hit) begin
               w_mv_nxt    = 1'b1;
               w_midx_nxt  = r_idx;
               w_state_nxt = S_DONE;
            end else if (w_last) begin
               w_hd_nxt    = r_def_en;
               w_state_nxt = S_DONE;
            end else begin
               w_idx_nxt   = IW'(r_idx + 1'b1);
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_match_valid <= 1'b0;
         r_match_idx   <= '0;
         r_hit_default <= 1'b0;
         r_sel_ext     <= '0;
         r_ctx_width   <= '0;
         r_ctx_signed  <= 1'b0;
         r_def_en      <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_match_valid <= w_mv_nxt;
         r_match_idx   <= w_midx_nxt;
         r_hit_default <= w_hd_nxt;
         if (w_latch) begin
            r_sel_ext    <= w_sel_ext;
            r_ctx_width  <= w_ctx_width;
            r_ctx_signed <= w_ctx_signed;
            r_def_en     <= bus.default_en;
         end
      end
   end

   // Table port is live in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid  <= '0;
         r_signed <= '0;
         for (int i = 0; i < N_ITEMS; i++) begin
            r_val[i]   <= '0;
            r_width[i] <= '0;
`ifdef CASE_SCAN_CASEZ_EN
            r_mask[i]  <= '0;
`endif
         end
      end else if (bus.cfg_we) begin
         r_valid[bus.cfg_idx]  <= bus.cfg_valid;
         r_signed[bus.cfg_idx] <= bus.cfg_signed;
         r_val[bus.cfg_idx]    <= bus.cfg_val;
         r_width[bus.cfg_idx]  <= bus.cfg_width;
`ifdef CASE_SCAN_CASEZ_EN
         r_mask[bus.cfg_idx]   <= bus.cfg_mask;
`endif
      end
   end

   assign bus.busy        = (r_state == S_SCAN);
   assign bus.done        = (r_state == S_DONE);
   assign bus.match_valid = r_match_valid;
   assign bus.match_idx   = r_match_idx;
   assign bus.hit_default = r_hit_default;
endmodule

// File: tb/tb_case_item_scanner.sv
// Self-checking bench for case_item_scanner: directed vector table, corner sequences,
// and randomized tables checked against an arithmetic model of the case rules.
module tb_case_item_scanner;
   localparam int N = 8;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   case_item_scanner_if #(.N_ITEMS(N), .W(W)) bus ();
   case_item_scanner #(.N_ITEMS(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]      sel;
      logic [3:0]      sw;
      logic            ss;
      logic            def;
      int              n;
      logic [2:0][2:0] ix;
      logic [2:0][7:0] v;
      logic [2:0][3:0] w;
      logic [2:0]      s;
      logic            mv;
      logic [2:0]      idx;
      logic            hd;
      int              lat;
   } vec_t;

   vec_t vt[12];

   // Shadow of the table for the reference model.
   bit   m_valid [N];
   int   m_val   [N];
   int   m_width [N];
   bit   m_sign  [N];
   int   m_mask  [N];

   function automatic vec_t mk(logic [7:0] sel, int sw, bit ss, bit def, int n,
                               int i0, int v0, int w0, bit s0,
                               int i1, int v1, int w1, bit s1,
                               int i2, int v2, int w2, bit s2,
                               bit mv, int idx, bit hd, int lat);
      vec_t r;
      r.sel = sel; r.sw = 4'(sw); r.ss = ss; r.def = def; r.n = n;
      r.ix[0] = 3'(i0); r.v[0] = 8'(v0); r.w[0] = 4'(w0); r.s[0] = s0;
      r.ix[1] = 3'(i1); r.v[1] = 8'(v1); r.w[1] = 4'(w1); r.s[1] = s1;
      r.ix[2] = 3'(i2); r.v[2] = 8'(v2); r.w[2] = 4'(w2); r.s[2] = s2;
      r.mv = mv; r.idx = 3'(idx); r.hd = hd; r.lat = lat;
      return r;
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic write_entry(int idx, bit vld, int val, int wd, bit sg, int mask);
      @(negedge clk);
      bus.cfg_we     = 1'b1;
      bus.cfg_idx    = 3'(idx);
      bus.cfg_valid  = vld;
      bus.cfg_val    = 8'(val);
      bus.cfg_width  = 4'(wd);
      bus.cfg_signed = sg;
`ifdef CASE_SCAN_CASEZ_EN
      bus.cfg_mask   = 8'(mask);
`endif
      @(negedge clk);
      bus.cfg_we = 1'b0;
      m_valid[idx] = vld; m_val[idx] = val & 255; m_width[idx] = wd;
      m_sign[idx] = sg; m_mask[idx] = mask & 255;
   endtask

   task automatic clear_table();
      for (int i = 0; i < N; i++) write_entry(i, 1'b0, 0, 1, 1'b0, 0);
   endtask

   task automatic clear_shadow();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_val[i] = 0; m_width[i] = 1; m_sign[i] = 0; m_mask[i] = 0;
      end
   endtask

   task automatic load_vec(vec_t v);
      clear_table();
      for (int j = 0; j < v.n; j++) write_entry(int'(v.ix[j]), 1'b1, int'(v.v[j]), int'(v.w[j]), v.s[j], 0);
   endtask

   function automatic longint to_val(longint v, int wd, bit cs);
      longint m;
      m = longint'(1) << wd;
      v = v % m;
      if (cs && v >= m / 2) v = v - m;
      return v;
   endfunction

   // Verilog case rules evaluated as integer arithmetic over the shadow table.
   task automatic model_scan(int sel, int sw, bit ss, bit def,
                             output bit mv, output int idx, output bit hd, output int lat);
      int     cw;
      bit     cs;
      longint a, b, mm, md;
      bit     eq;
      cw = sw; cs = ss;
      for (int i = 0; i < N; i++)
         if (m_valid[i]) begin
            if (m_width[i] > cw) cw = m_width[i];
            cs = cs & m_sign[i];
         end
      md = longint'(1) << cw;
      a  = ((to_val(sel, sw, cs) % md) + md) % md;
      mv = 0; idx = 0; hd = 0; lat = N;
      for (int i = 0; i < N; i++) begin
         if (!m_valid[i]) continue;
         b  = ((to_val(m_val[i], m_width[i], cs) % md) + md) % md;
`ifdef CASE_SCAN_CASEZ_EN
         mm = ((to_val(m_mask[i], m_width[i], 1'b1) % md) + md) % md;
`else
         mm = 0;
`endif
         eq = (((a ^ b) & ~mm & (md - 1)) == 0);
         if (eq) begin
            mv = 1; idx = i; lat = i + 1;
            break;
         end
      end
      if (!mv) hd = def;
   endtask

   task automatic run_scan(string nm, int sel, int sw, bit ss, bit def,
                           bit emv, int eidx, bit ehd, int elat);
      int cyc;
      @(negedge clk);
      bus.sel_val = 8'(sel); bus.sel_width = 4'(sw); bus.sel_signed = ss;
      bus.default_en = def; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      chk({nm, " busy"}, int'(bus.busy), 1);
      while (!bus.done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, " latency"}, cyc, elat);
      chk({nm, " match_valid"}, int'(bus.match_valid), int'(emv));
      if (emv) chk({nm, " match_idx"}, int'(bus.match_idx), eidx);
      chk({nm, " hit_default"}, int'(bus.hit_default), int'(ehd));
      chk({nm, " busy at done"}, int'(bus.busy), 0);
      @(negedge clk);
      chk({nm, " done one cycle"}, int'(bus.done), 0);
      chk({nm, " match held"}, int'(bus.match_valid), int'(emv));
   endtask

   initial begin
      int  seen, cyc, m_idx, m_lat, sw, s_val;
      bit  m_mv, m_hd, ss, df;

      vt[0]  = mk(8'h00, 2, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      vt[1]  = mk(8'h03, 2, 1, 0, 2, 0, 8'h01, 2, 1, 1, 8'h01, 1, 1, 0, 0, 0, 0, 1, 1, 0, 2);
      vt[2]  = mk(8'h03, 2, 1, 1, 2, 0, 8'h00, 1, 0, 1, 8'h01, 1, 1, 0, 0, 0, 0, 0, 0, 1, 8);
      vt[3]  = mk(8'h01, 1, 1, 1, 3, 0, 8'h00, 1, 1, 1, 8'h00, 3, 0, 2, 8'h03, 2, 1, 0, 0, 1, 8);
      vt[4]  = mk(8'h55, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
      vt[5]  = mk(8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);
      vt[6]  = mk(8'h5A, 8, 0, 1, 2, 3, 8'h5A, 8, 0, 5, 8'h5A, 8, 0, 0, 0, 0, 0, 1, 3, 0, 4);
      vt[7]  = mk(8'h3C, 8, 0, 1, 1, 7, 8'h3C, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 8);
      vt[8]  = mk(8'hFF, 8, 1, 0, 2, 1, 8'h7F, 8, 1, 2, 8'h0F, 4, 1, 0, 0, 0, 0, 1, 2, 0, 3);
      vt[9]  = mk(8'h03, 2, 0, 0, 1, 0, 8'hF3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      vt[10] = mk(8'hFF, 8, 1, 0, 1, 0, 8'h0F, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
      vt[11] = mk(8'h0F, 4, 1, 0, 1, 4, 8'hFF, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 5);

      bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_valid = 0; bus.cfg_val = 0;
      bus.cfg_width = 1; bus.cfg_signed = 0; bus.default_en = 0; bus.start = 0;
      bus.sel_val = 0; bus.sel_width = 1; bus.sel_signed = 0;
`ifdef CASE_SCAN_CASEZ_EN
      bus.cfg_mask = 0;
`endif
      clear_shadow();
      rst_n = 1'b0;
      #12;
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      chk("reset match_valid", int'(bus.match_valid), 0);
      chk("reset match_idx", int'(bus.match_idx), 0);
      chk("reset hit_default", int'(bus.hit_default), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 12; t++) begin
         load_vec(vt[t]);
         run_scan($sformatf("vec%0d", t), int'(vt[t].sel), int'(vt[t].sw), vt[t].ss, vt[t].def,
                  vt[t].mv, int'(vt[t].idx), vt[t].hd, vt[t].lat);
      end

      // A start pulse during a scan must not disturb it.
      load_vec(vt[6]);
      @(negedge clk);
      bus.sel_val = 8'h5A; bus.sel_width = 8; bus.sel_signed = 0; bus.default_en = 1;
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      @(negedge clk);
      bus.start = 1; bus.sel_val = 8'h00;
      @(negedge clk);
      bus.start = 0;
      cyc = 2;
      while (!bus.done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("restart ignored latency", cyc, 4);
      chk("restart ignored idx", int'(bus.match_idx), 3);
      @(negedge clk);
      chk("idle after done", int'(bus.busy), 0);

      // Reset during a scan aborts with no done pulse.
      load_vec(vt[2]);
      @(negedge clk);
      bus.sel_val = 8'h03; bus.sel_width = 2; bus.sel_signed = 1; bus.default_en = 1;
      bus.start = 1;
      @(negedge clk);
      bus.start = 0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy", int'(bus.busy), 0);
      chk("abort done", int'(bus.done), 0);
      chk("abort match_valid", int'(bus.match_valid), 0);
      chk("abort hit_default", int'(bus.hit_default), 0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("abort no done", seen, 0);
      rst_n = 1'b1;
      clear_shadow();
      load_vec(vt[1]);
      run_scan("post reset", 3, 2, 1, 0, 1, 1, 0, 2);

`ifdef CASE_SCAN_CASEZ_EN
      clear_table();
      write_entry(0, 1, 8'hA0, 8, 0, 8'h0F);
      run_scan("casez", 8'hA5, 8, 0, 0, 1, 0, 0, 1);
`endif

      // Randomized tables with narrow widths so matches are common.
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N; i++)
            write_entry(i, bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                        int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)),
                        int'($urandom & $urandom & 8'hFF));
         sw = int'($urandom_range(1, 4));
         s_val = int'($urandom_range(0, 255));
         ss = bit'($urandom_range(0, 1));
         df = bit'($urandom_range(0, 1));
         model_scan(s_val, sw, ss, df, m_mv, m_idx, m_hd, m_lat);
         run_scan($sformatf("rand%0d", it), s_val, sw, ss, df, m_mv, m_idx, m_hd, m_lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
